fs_dev_mem: RTL and testbench



---
 rtl/fs_dev_mem.sv | 168 ++++++++++++++++
 tb/tb_fs_dev_mem.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fs_dev_mem.sv
// Filesystem endpoint for the paged RAM swap port: resolves streamed filename words to
// /dev/mem or /dev/memmeta and serves word reads/writes. Optional counters: FS_DEV_MEM_STATS_EN.
module fs_dev_mem #(
    parameter int ADDR_W = 20,
    parameter int META_W = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fsAccess,
    input  logic        fsRden,
    input  logic        fsWren,
    input  logic [31:0] fsFilename,
    input  logic [31:0] fsAddress,
    input  logic [31:0] fsData,
    output logic [31:0] fsQ,
    output logic [1:0]  fsOpen,
`ifdef FS_DEV_MEM_STATS_EN
    output logic [31:0] fsReadCount,
    output logic [31:0] fsWriteCount,
`endif
    output logic        fsErr
);

    typedef enum logic [1:0] {
        FILE_NONE = 2'd0,
        FILE_MEM  = 2'd1,
        FILE_META = 2'd2
    } file_e;

    // ASCII name words as they arrive on the bus, first character in the top byte.
    localparam logic [31:0] NAME_DEV  = 32'h2F64_6576;  // "/dev"
    localparam logic [31:0] NAME_MEM  = 32'h2F6D_656D;  // "/mem"
    localparam logic [31:0] NAME_META = 32'h6D65_7461;  // "meta"

    logic [31:0] name_q [3];
    logic [1:0]  cnt_q;
    file_e       open_q;

    logic [31:0] mem  [2**ADDR_W];
    logic [3:0]  meta [2**META_W];

    logic        word_valid;
    logic        terminator;
    logic        overflow;
    file_e       match;
    file_e       eff;
    logic        req;
    logic        addr_oob;
    logic        rd_ok;
    logic        wr_ok;
    logic        do_read;
    logic        do_write;
    logic        err_set;
    logic [ADDR_W-1:0] mem_idx;
    logic [META_W-1:0] meta_idx;

    assign word_valid = fsAccess && (fsFilename != '0);
    assign terminator = fsAccess && (fsFilename == '0) && (cnt_q != 2'd0);
    assign overflow   = word_valid && (cnt_q == 2'd3);
    assign req        = fsRden || fsWren;
    assign mem_idx    = fsAddress[ADDR_W-1:0];
    assign meta_idx   = fsAddress[META_W-1:0];

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        match = FILE_NONE;
        if (cnt_q == 2'd2 && name_q[0] == NAME_DEV && name_q[1] == NAME_MEM)
            match = FILE_MEM;
        else if (cnt_q == 2'd3 && name_q[0] == NAME_DEV && name_q[1] == NAME_MEM
                 && name_q[2] == NAME_META)
            match = FILE_META;
    end

    // A request in the terminator cycle already targets the freshly matched file.
    always_comb begin
        eff = open_q;
        if (!fsAccess || word_valid)
            eff = FILE_NONE;
        else if (terminator)
            eff = match;
    end

    always_comb begin
        addr_oob = 1'b0;
        if (eff == FILE_MEM)
            addr_oob = (fsAddress >> ADDR_W) != '0;
        else if (eff == FILE_META)
            addr_oob = (fsAddress >> META_W) != '0;
    end

    assign rd_ok    = fsRden && (eff != FILE_NONE);
    assign wr_ok    = fsWren && (eff != FILE_NONE);
    assign do_read  = rd_ok && !addr_oob;
    assign do_write = wr_ok && !addr_oob;
    assign err_set  = (req && eff == FILE_NONE) || (req && addr_oob)
                    || (terminator && match == FILE_NONE) || overflow;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || !fsAccess) begin
            open_q <= FILE_NONE;
            cnt_q  <= 2'd0;
            for (int i = 0; i < 3; i++) name_q[i] <= '0;
        end else if (terminator) begin
            open_q <= match;
            cnt_q  <= 2'd0;
            for (int i = 0; i < 3; i++) name_q[i] <= '0;
        end else if (word_valid) begin
            open_q <= FILE_NONE;
            if (overflow) begin
                cnt_q <= 2'd0;
                for (int i = 0; i < 3; i++) name_q[i] <= '0;
            end else begin
                name_q[cnt_q] <= fsFilename;
                cnt_q         <= cnt_q + 2'd1;
            end
        end
    end

    assign fsOpen = open_q;

    // NOTE: the backing stores have no reset; clearing megabytes of RAM in one edge is not possible.
    always_ff @(posedge clk) begin
        if (!rst && do_write && eff == FILE_MEM)
            mem[mem_idx] <= fsData;
    end

    always_ff @(posedge clk) begin
        if (!rst && do_write && eff == FILE_META)
            meta[meta_idx] <= fsData[3:0];
    end

    // Reads sample the store before this edge's write lands, giving read-before-write.
    always_ff @(posedge clk) begin
        if (rst)
            fsQ <= '0;
        else if (rd_ok) begin
            if (addr_oob)
                fsQ <= '0;
            else if (eff == FILE_MEM)
                fsQ <= mem[mem_idx];
            else
                fsQ <= {28'b0, meta[meta_idx]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            fsErr <= 1'b0;
        else if (err_set)
            fsErr <= 1'b1;
    end

`ifdef FS_DEV_MEM_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fsReadCount  <= '0;
            fsWriteCount <= '0;
        end else begin
            if (do_read && fsReadCount != 32'hFFFF_FFFF)
                fsReadCount <= fsReadCount + 32'd1;
            if (do_write && fsWriteCount != 32'hFFFF_FFFF)
                fsWriteCount <= fsWriteCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fs_dev_mem.sv
// Directed self-checking bench for fs_dev_mem; stats checks build when FS_DEV_MEM_STATS_EN is defined.
module tb_fs_dev_mem;

    localparam int ADDR_W = 20;
    localparam int META_W = 14;
    localparam logic [31:0] W_DEV  = "/dev";
    localparam logic [31:0] W_MEM  = "/mem";
    localparam logic [31:0] W_META = "meta";
    localparam logic [31:0] W_FOO  = "/foo";

    logic        clk = 1'b0;
    logic        rst;
    logic        fsAccess, fsRden, fsWren;
    logic [31:0] fsFilename, fsAddress, fsData;
    logic [31:0] fsQ;
    logic [1:0]  fsOpen;
    logic        fsErr;
`ifdef FS_DEV_MEM_STATS_EN
    logic [31:0] fsReadCount, fsWriteCount;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fs_dev_mem #(.ADDR_W(ADDR_W), .META_W(META_W)) dut (
        .clk(clk), .rst(rst),
        .fsAccess(fsAccess), .fsRden(fsRden), .fsWren(fsWren),
        .fsFilename(fsFilename), .fsAddress(fsAddress), .fsData(fsData),
        .fsQ(fsQ), .fsOpen(fsOpen),
`ifdef FS_DEV_MEM_STATS_EN
        .fsReadCount(fsReadCount), .fsWriteCount(fsWriteCount),
`endif
        .fsErr(fsErr)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic acc, input logic rd, input logic wr,
                         input logic [31:0] fname, input logic [31:0] addr, input logic [31:0] data);
        fsAccess = acc; fsRden = rd; fsWren = wr;
        fsFilename = fname; fsAddress = addr; fsData = data;
        tick();
    endtask

    task automatic open_mem();
        drive(1, 0, 0, W_DEV, 0, 0);
        drive(1, 0, 0, W_MEM, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        n_checks++; if (fsQ !== 32'h0) begin n_fail++; $display("FAIL reset_q: got %h want %h", fsQ, 32'h0); end
        n_checks++; if (fsOpen !== 2'd0) begin n_fail++; $display("FAIL reset_open: got %0d want 0", fsOpen); end
        n_checks++; if (fsErr !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", fsErr); end
    endtask

    task automatic test_open_mem();
        open_mem();
        n_checks++; if (fsOpen !== 2'd1) begin n_fail++; $display("FAIL open_mem: got %0d want 1", fsOpen); end
        drive(1, 0, 1, 0, 5, 32'hDEADBEEF);
        drive(1, 1, 0, 0, 5, 0);
        n_checks++; if (fsQ !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mem_rd5: got %h want deadbeef", fsQ); end
        n_checks++; if (fsErr !== 1'b0) begin n_fail++; $display("FAIL mem_err: got %b want 0", fsErr); end
    endtask

    task automatic test_meta_terminator();
        drive(1, 0, 0, W_DEV, 0, 0);
        drive(1, 0, 0, W_MEM, 0, 0);
        drive(1, 0, 0, W_META, 0, 0);
        drive(1, 0, 1, 0, 3, 32'h0000000A);
        n_checks++; if (fsOpen !== 2'd2) begin n_fail++; $display("FAIL open_meta: got %0d want 2", fsOpen); end
        drive(1, 1, 0, 0, 3, 0);
        n_checks++; if (fsQ !== 32'h0000000A) begin n_fail++; $display("FAIL meta_rd3: got %h want 0000000a", fsQ); end
    endtask

    task automatic test_back_to_back();
        open_mem();
        drive(1, 0, 1, 0, 7, 1);
        drive(1, 0, 1, 0, 8, 2);
        drive(1, 1, 1, 0, 7, 99);
        n_checks++; if (fsQ !== 32'd1) begin n_fail++; $display("FAIL rbw_old: got %0d want 1", fsQ); end
        drive(1, 1, 0, 0, 7, 0);
        n_checks++; if (fsQ !== 32'd99) begin n_fail++; $display("FAIL b2b_rd7: got %0d want 99", fsQ); end
        drive(1, 1, 0, 0, 8, 0);
        n_checks++; if (fsQ !== 32'd2) begin n_fail++; $display("FAIL b2b_rd8: got %0d want 2", fsQ); end
        n_checks++; if (fsErr !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got %b want 0", fsErr); end
    endtask

    task automatic test_bad_name();
        drive(1, 0, 0, W_DEV, 0, 0);
        drive(1, 0, 0, W_FOO, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        n_checks++; if (fsOpen !== 2'd0) begin n_fail++; $display("FAIL bad_open: got %0d want 0", fsOpen); end
        n_checks++; if (fsErr !== 1'b1) begin n_fail++; $display("FAIL bad_err: got %b want 1", fsErr); end
        drive(1, 1, 0, 0, 7, 0);
        n_checks++; if (fsQ !== 32'd2) begin n_fail++; $display("FAIL nofile_hold: got %0d want 2", fsQ); end
        drive(1, 0, 1, 0, 5, 32'h12345678);
        open_mem();
        drive(1, 1, 0, 0, 5, 0);
        n_checks++; if (fsQ !== 32'hDEADBEEF) begin n_fail++; $display("FAIL nofile_wr: got %h want deadbeef", fsQ); end
    endtask

    task automatic test_close();
        n_checks++; if (fsOpen !== 2'd1) begin n_fail++; $display("FAIL pre_close: got %0d want 1", fsOpen); end
        drive(0, 0, 0, 0, 0, 0);
        n_checks++; if (fsOpen !== 2'd0) begin n_fail++; $display("FAIL close: got %0d want 0", fsOpen); end
    endtask

    task automatic test_range();
        do_reset();
        open_mem();
        drive(1, 1, 0, 0, 7, 0);
        n_checks++; if (fsQ !== 32'd99) begin n_fail++; $display("FAIL rng_rd7: got %0d want 99", fsQ); end
        n_checks++; if (fsErr !== 1'b0) begin n_fail++; $display("FAIL rng_err0: got %b want 0", fsErr); end
        drive(1, 1, 0, 0, 32'h1 << ADDR_W, 0);
        n_checks++; if (fsQ !== 32'h0) begin n_fail++; $display("FAIL oob_rd: got %h want 0", fsQ); end
        n_checks++; if (fsErr !== 1'b1) begin n_fail++; $display("FAIL oob_err: got %b want 1", fsErr); end
        drive(1, 0, 1, 0, (32'h1 << ADDR_W) | 32'd7, 55);
        drive(1, 1, 0, 0, 7, 0);
        n_checks++; if (fsQ !== 32'd99) begin n_fail++; $display("FAIL oob_wr: got %0d want 99", fsQ); end
        drive(1, 0, 0, W_DEV, 0, 0);
        drive(1, 0, 0, W_MEM, 0, 0);
        drive(1, 0, 0, W_META, 0, 0);
        drive(1, 1, 0, 0, 3, 0);
        n_checks++; if (fsQ !== 32'hA) begin n_fail++; $display("FAIL meta_rd3b: got %h want a", fsQ); end
        drive(1, 1, 0, 0, (32'h1 << META_W) | 32'd3, 0);
        n_checks++; if (fsQ !== 32'h0) begin n_fail++; $display("FAIL meta_oob: got %h want 0", fsQ); end
    endtask

    task automatic test_reset_mid_name();
        do_reset();
        n_checks++; if (fsErr !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", fsErr); end
        drive(1, 0, 0, W_DEV, 0, 0);
        rst = 1'b1;
        drive(1, 0, 0, 0, 0, 0);
        rst = 1'b0;
        drive(1, 0, 0, W_MEM, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        n_checks++; if (fsOpen !== 2'd0) begin n_fail++; $display("FAIL cut_open: got %0d want 0", fsOpen); end
        n_checks++; if (fsErr !== 1'b1) begin n_fail++; $display("FAIL cut_err: got %b want 1", fsErr); end
    endtask

`ifdef FS_DEV_MEM_STATS_EN
    task automatic test_stats();
        do_reset();
        open_mem();
        drive(1, 0, 1, 0, 10, 10);
        drive(1, 0, 1, 0, 11, 11);
        drive(1, 0, 1, 0, 12, 12);
        drive(1, 1, 0, 0, 10, 0);
        drive(1, 1, 0, 0, 11, 0);
        drive(1, 1, 0, 0, 32'h1 << ADDR_W, 0);
        n_checks++; if (fsWriteCount !== 32'd3) begin n_fail++; $display("FAIL wr_count: got %0d want 3", fsWriteCount); end
        n_checks++; if (fsReadCount !== 32'd2) begin n_fail++; $display("FAIL rd_count: got %0d want 2", fsReadCount); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        fsAccess = 0; fsRden = 0; fsWren = 0;
        fsFilename = '0; fsAddress = '0; fsData = '0;
        test_reset();
        test_open_mem();
        test_meta_terminator();
        test_back_to_back();
        test_bad_name();
        test_close();
        test_range();
        test_reset_mid_name();
`ifdef FS_DEV_MEM_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
